// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the combinational ROM address and
// buffers one fetched word for decode behind a valid/ready handshake.
module instr_fetch_ctrl #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int RESET_PC  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_halt_req,
  input  logic                   i_jump_valid,
  input  logic [ADDR_BITS-1:0]   i_jump_addr,
  output logic [ADDR_BITS-1:0]   o_rom_addr,
  input  logic [2*DATA_BITS-1:0] i_rom_data,
  output logic                   o_instr_valid,
  input  logic                   i_instr_ready,
  output logic [2*DATA_BITS-1:0] o_instr_data,
  output logic [ADDR_BITS-1:0]   o_instr_pc,
  output logic                   o_running
);

  // state | meaning
  // IDLE  | out of reset, waiting for start or jump
  // RUN   | issuing fetches whenever the output slot is free
  // HALT  | fetching stopped, PC holds next unfetched address
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_BITS-1:0] LP_RESET_PC = ADDR_BITS'(RESET_PC);
  localparam logic [ADDR_BITS-1:0] LP_PC_ONE   = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_BITS-1:0]   r_pc;
  logic                   r_valid;
  logic [2*DATA_BITS-1:0] r_data;
  logic [ADDR_BITS-1:0]   r_instr_pc;

  logic w_accept;
  logic w_slot_free;
  logic w_fetch;

  assign w_accept    = r_valid & i_instr_ready;
  assign w_slot_free = ~r_valid | w_accept;
  assign w_fetch     = (r_state == RUN) & w_slot_free & ~i_jump_valid & ~i_halt_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Jump outranks halt, and halt outranks start, in every state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, HALT: begin
        if (i_jump_valid) begin
          w_state_nxt = RUN;
        end else if (i_start && !i_halt_req) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_halt_req && !i_jump_valid) begin
          w_state_nxt = HALT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A jump flushes the buffer even if decode accepts the old word in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= LP_RESET_PC;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_instr_pc <= '0;
    end else if (i_jump_valid) begin
      r_pc    <= i_jump_addr;
      r_valid <= 1'b0;
    end else if (w_fetch) begin
      r_data     <= i_rom_data;
      r_instr_pc <= r_pc;
      r_valid    <= 1'b1;
      r_pc       <= r_pc + LP_PC_ONE;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign o_rom_addr    = r_pc;
  assign o_instr_valid = r_valid;
  assign o_instr_data  = r_data;
  assign o_instr_pc    = r_instr_pc;
  assign o_running     = (r_state == RUN);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: an 8-bit-address instance for the main scenarios
// and a 4-bit-address instance for PC wrap.
module tb_instr_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, halt_req, jump_valid, ready;
  logic [7:0]  jump_addr, rom_addr, ipc;
  logic [15:0] rom_data, idata;
  logic        ivalid, running;

  logic        s4, h4, j4, r4;
  logic [3:0]  ja4, ra4, ipc4;
  logic [15:0] rd4, idata4;
  logic        iv4, run4;

  int errors = 0;
  int checks = 0;

  assign rom_data = 16'h0100 + {8'h00, rom_addr};
  assign rd4      = 16'h0100 + {12'h000, ra4};

  instr_fetch_ctrl #(.ADDR_BITS(8), .DATA_BITS(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_halt_req(halt_req),
    .i_jump_valid(jump_valid), .i_jump_addr(jump_addr), .o_rom_addr(rom_addr),
    .i_rom_data(rom_data), .o_instr_valid(ivalid), .i_instr_ready(ready),
    .o_instr_data(idata), .o_instr_pc(ipc), .o_running(running)
  );

  instr_fetch_ctrl #(.ADDR_BITS(4), .DATA_BITS(8), .RESET_PC(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_start(s4), .i_halt_req(h4),
    .i_jump_valid(j4), .i_jump_addr(ja4), .o_rom_addr(ra4),
    .i_rom_data(rd4), .o_instr_valid(iv4), .i_instr_ready(r4),
    .o_instr_data(idata4), .o_instr_pc(ipc4), .o_running(run4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    start = 0; halt_req = 0; jump_valid = 0; jump_addr = 0; ready = 0;
    s4 = 0; h4 = 0; j4 = 0; ja4 = 0; r4 = 0;
    rst_n = 0;
    tick();
    checks++;
    if (ivalid !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL reset_flags: valid=%b running=%b, want 0 0", ivalid, running);
    end
    checks++;
    if (idata !== 16'h0 || ipc !== 8'h0 || rom_addr !== 8'h0) begin
      errors++; $display("FAIL reset_data: data=%h pc=%h rom_addr=%h, want 0 0 0", idata, ipc, rom_addr);
    end
    rst_n = 1;
    tick();
    tick();
    checks++;
    if (ivalid !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL idle_hold: valid=%b running=%b, want 0 0", ivalid, running);
    end
  endtask

  task automatic test_stream();
    ready = 1; start = 1;
    tick();
    start = 0;
    checks++;
    if (running !== 1'b1 || ivalid !== 1'b0) begin
      errors++; $display("FAIL start_latency: running=%b valid=%b, want 1 0", running, ivalid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ivalid !== 1'b1 || ipc !== 8'(i) || idata !== 16'(16'h100 + i)) begin
        errors++; $display("FAIL stream[%0d]: valid=%b pc=%h data=%h, want 1 %h %h",
                           i, ivalid, ipc, idata, 8'(i), 16'(16'h100 + i));
      end
    end
  endtask

  task automatic test_backpressure();
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ivalid !== 1'b1 || ipc !== 8'h04 || idata !== 16'h0104 || rom_addr !== 8'h05) begin
        errors++; $display("FAIL stall[%0d]: valid=%b pc=%h data=%h rom_addr=%h, want 1 04 0104 05",
                           i, ivalid, ipc, idata, rom_addr);
      end
    end
    ready = 1;
    tick();
    checks++;
    if (ivalid !== 1'b1 || ipc !== 8'h05 || idata !== 16'h0105) begin
      errors++; $display("FAIL resume: valid=%b pc=%h data=%h, want 1 05 0105", ivalid, ipc, idata);
    end
  endtask

  task automatic test_jump();
    ready = 0; jump_valid = 1; jump_addr = 8'h40;
    tick();
    jump_valid = 0; jump_addr = 8'h00;
    checks++;
    if (ivalid !== 1'b0 || rom_addr !== 8'h40 || running !== 1'b1) begin
      errors++; $display("FAIL jump_flush: valid=%b rom_addr=%h running=%b, want 0 40 1",
                         ivalid, rom_addr, running);
    end
    ready = 1;
    tick();
    checks++;
    if (ivalid !== 1'b1 || ipc !== 8'h40 || idata !== 16'h0140) begin
      errors++; $display("FAIL jump_target: valid=%b pc=%h data=%h, want 1 40 0140", ivalid, ipc, idata);
    end
    tick();
    checks++;
    if (ivalid !== 1'b1 || ipc !== 8'h41 || idata !== 16'h0141) begin
      errors++; $display("FAIL jump_next: valid=%b pc=%h data=%h, want 1 41 0141", ivalid, ipc, idata);
    end
  endtask

  task automatic test_halt();
    halt_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ivalid !== 1'b0 || running !== 1'b0 || rom_addr !== 8'h42) begin
        errors++; $display("FAIL halt[%0d]: valid=%b running=%b rom_addr=%h, want 0 0 42",
                           i, ivalid, running, rom_addr);
      end
    end
    halt_req = 0; start = 1;
    tick();
    start = 0;
    checks++;
    if (running !== 1'b1 || ivalid !== 1'b0) begin
      errors++; $display("FAIL halt_restart: running=%b valid=%b, want 1 0", running, ivalid);
    end
    tick();
    checks++;
    if (ivalid !== 1'b1 || ipc !== 8'h42 || idata !== 16'h0142) begin
      errors++; $display("FAIL halt_resume: valid=%b pc=%h data=%h, want 1 42 0142", ivalid, ipc, idata);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_pc [4];
    exp_pc[0] = 4'd14; exp_pc[1] = 4'd15; exp_pc[2] = 4'd0; exp_pc[3] = 4'd1;
    r4 = 1; j4 = 1; ja4 = 4'd14;
    tick();
    j4 = 0; ja4 = 4'd0;
    checks++;
    if (run4 !== 1'b1 || iv4 !== 1'b0 || ra4 !== 4'd14) begin
      errors++; $display("FAIL wrap_jump: running=%b valid=%b rom_addr=%0d, want 1 0 14", run4, iv4, ra4);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (iv4 !== 1'b1 || ipc4 !== exp_pc[i] || idata4 !== (16'h0100 + {12'h000, exp_pc[i]})) begin
        errors++; $display("FAIL wrap[%0d]: valid=%b pc=%0d data=%h, want 1 %0d", i, iv4, ipc4, idata4, exp_pc[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    checks++;
    if (ivalid !== 1'b0 || running !== 1'b0 || idata !== 16'h0 || ipc !== 8'h0 || rom_addr !== 8'h0) begin
      errors++; $display("FAIL async_reset: valid=%b running=%b data=%h pc=%h rom_addr=%h, want all 0",
                         ivalid, running, idata, ipc, rom_addr);
    end
    #1;
    rst_n = 1;
    tick();
    tick();
    checks++;
    if (ivalid !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: valid=%b running=%b, want 0 0", ivalid, running);
    end
    start = 1;
    tick();
    start = 0;
    tick();
    checks++;
    if (ivalid !== 1'b1 || ipc !== 8'h00 || idata !== 16'h0100) begin
      errors++; $display("FAIL post_reset_first: valid=%b pc=%h data=%h, want 1 00 0100", ivalid, ipc, idata);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
